// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : FETCH (assembling a word from ROM bytes) / HOLD (buffer full)
//   fetch_entry_t : one prefetch buffer slot, {pc, instr}
//   BYTES_PER_WORD: ROM bytes assembled per instruction word
//   BUF_DEPTH     : prefetch buffer depth
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BUF_DEPTH      = 2;

    // Widths of the fields stored in a buffer slot.
    localparam int PC_W    = 32;
    localparam int INSTR_W = 8 * BYTES_PER_WORD;

    // Occupancy counter must hold 0..BUF_DEPTH.
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry synchronous FIFO holding fetched instruction words.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (empties the FIFO)
//   flush       : empties the FIFO; wins over push and pop in the same cycle
//   push        : write push_entry at the tail (ignored when full)
//   push_entry  : {pc, instr} to write
//   pop         : drop the head entry (ignored when empty)
//   head        : entry at the head of the FIFO
//   head_valid  : FIFO non-empty
//   count       : number of stored entries (0..BUF_DEPTH)
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && (count != CNT_W'(BUF_DEPTH));
        do_pop  = pop  && (count != '0);
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_comb begin
        head       = mem[rd_ptr];
        head_valid = (count != '0);
    end

endmodule : fetch_buf

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
// Fetches instructions from a byte-wide ROM one byte per cycle, assembles four
// little-endian bytes into a word and queues {pc, word} in a 2-entry prefetch
// buffer that the decode stage drains over a valid/ready handshake. Redirects
// flush every in-flight and buffered word and restart fetch at the target.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rom_addr        : byte address presented to the ROM
//   rom_data        : ROM byte for rom_addr, same cycle
//   instr, instr_pc : buffer head word and its PC (0 when buffer empty)
//   instr_valid     : buffer non-empty
//   instr_ready     : consumer takes the head when instr_valid is also high
//   redirect_valid  : load redirect_pc (word aligned) and flush
//   redirect_pc     : redirect target
//   fetch_busy      : sequencer is in the FETCH state
// -----------------------------------------------------------------------------
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [7:0]               rom_data,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     fetch_busy
);

    fetch_state_t             state;
    logic [1:0]               byte_idx;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [23:0]              asm_word;

    logic                     word_done;
    logic                     push;
    logic                     pop;
    logic [CNT_W-1:0]         buf_count;
    logic [CNT_W-1:0]         count_next;
    fetch_entry_t             push_entry;
    fetch_entry_t             head;
    logic                     head_valid;

    always_comb begin
        word_done = (state == FETCH) && (byte_idx == 2'd3);
        // A redirect discards the word being completed and ignores any pop.
        push      = word_done && !redirect_valid;
        pop       = head_valid && instr_ready && !redirect_valid;

        case ({push, pop})
            2'b10:   count_next = buf_count + 1'b1;
            2'b01:   count_next = buf_count - 1'b1;
            default: count_next = buf_count;
        endcase

        push_entry.pc    = PC_W'(pc);
        push_entry.instr = INSTR_W'({rom_data, asm_word});
    end

    // pc is word aligned, so the byte index simply fills the low two bits and
    // a word fetch never crosses a word boundary (including at the top of the
    // address space).
    always_comb begin
        if (state == FETCH) begin
            rom_addr = {pc[ADDRESS_WIDTH-1:2], byte_idx};
        end else begin
            rom_addr = pc;
        end
        fetch_busy = (state == FETCH);
    end

    // Sequencer: state, byte index and program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            byte_idx <= 2'd0;
            pc       <= RESET_PC;
        end else if (redirect_valid) begin
            state    <= FETCH;
            byte_idx <= 2'd0;
            pc       <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end else begin
            case (state)
                FETCH: begin
                    byte_idx <= byte_idx + 2'd1;
                    if (word_done) begin
                        pc <= pc + ADDRESS_WIDTH'(BYTES_PER_WORD);
                        // Only start another word while a slot is free.
                        state <= (count_next == CNT_W'(BUF_DEPTH)) ? HOLD : FETCH;
                    end
                end
                HOLD: begin
                    if (pop) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Byte assembly for the low three bytes; the top byte is taken straight
    // from the ROM in the cycle the word is written.
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            case (byte_idx)
                2'd0:    asm_word[7:0]   <= rom_data;
                2'd1:    asm_word[15:8]  <= rom_data;
                2'd2:    asm_word[23:16] <= rom_data;
                default: asm_word        <= asm_word;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (buf_count)
    );

    always_comb begin
        instr_valid = head_valid;
        instr       = head_valid ? DATA_WIDTH'(head.instr)  : '0;
        instr_pc    = head_valid ? ADDRESS_WIDTH'(head.pc)  : '0;
    end

endmodule : instr_fetch_seq

// File: tb/tb_instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_seq
// Bench for instr_fetch_seq: a main instance at RESET_PC=0 and a second
// instance at RESET_PC=0xFFFF_FFFC for the address wrap case. A queue holds
// the {pc, instr} words the consumer is expected to accept, in order.
// -----------------------------------------------------------------------------
module tb_instr_fetch_seq;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_busy;

    logic [31:0] rom_addr_w;
    logic [7:0]  rom_data_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_valid_w;
    logic        fetch_busy_w;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'd0:   rom_byte = 8'h13;
            32'd1:   rom_byte = 8'h05;
            32'd2:   rom_byte = 8'hA0;
            32'd3:   rom_byte = 8'h00;
            32'd4:   rom_byte = 8'h93;
            32'd5:   rom_byte = 8'h05;
            32'd6:   rom_byte = 8'h10;
            32'd7:   rom_byte = 8'h00;
            default: rom_byte = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        exp_word = {rom_byte(pc + 32'd3), rom_byte(pc + 32'd2),
                    rom_byte(pc + 32'd1), rom_byte(pc)};
    endfunction

    always_comb rom_data   = rom_byte(rom_addr);
    always_comb rom_data_w = rom_byte(rom_addr_w);

    instr_fetch_seq #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
    );

    instr_fetch_seq #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'hFFFF_FFFC)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr_w),
        .rom_data       (rom_data_w),
        .instr          (instr_w),
        .instr_pc       (instr_pc_w),
        .instr_valid    (instr_valid_w),
        .instr_ready    (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .fetch_busy     (fetch_busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Just before the edge, a word the consumer is about
    // to accept is compared with the oldest expected word.
    task automatic tick();
        exp_t e;
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no word", instr_pc, instr);
            end else begin
                e = sb_q.pop_front();
                if (instr_pc !== e.pc || instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc    = pc;
        e.instr = word;
        sb_q.push_back(e);
    endtask

    // Leaves rst low: the caller is then in cycle 0.
    task automatic apply_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        tick();
        tick();
        sb_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        tick();
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0", instr_pc); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h, required 0", rom_addr); end
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", fetch_busy); end
        checks++; if (rom_addr_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_rom_addr_w: got %h, required fffffffc", rom_addr_w); end
    endtask

    task automatic test_basic();
        logic exp_v;
        apply_reset();
        instr_ready = 1'b1;
        push_exp(32'h0, 32'h00A0_0513);
        push_exp(32'h4, 32'h0010_0593);
        for (int c = 0; c < 9; c++) begin
            checks++; if (rom_addr !== 32'(c)) begin errors++; $display("FAIL basic_rom_addr c%0d: got %h, required %h", c, rom_addr, 32'(c)); end
            exp_v = (c == 4) || (c == 8);
            checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL basic_valid c%0d: got %b, required %b", c, instr_valid, exp_v); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        instr_ready = 1'b0;
        push_exp(32'h0, exp_word(32'h0));
        push_exp(32'h4, exp_word(32'h4));
        push_exp(32'h8, exp_word(32'h8));
        repeat (8) tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL bp_hold_busy k%0d: got %b, required 0", k, fetch_busy); end
            checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL bp_hold_addr k%0d: got %h, required 8", k, rom_addr); end
            checks++; if (instr_pc !== 32'h0 || instr !== 32'h00A0_0513) begin errors++; $display("FAIL bp_hold_head k%0d: got pc=%h instr=%h, required pc=0 instr=00a00513", k, instr_pc, instr); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL bp_new_head: got %h, required 4", instr_pc); end
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL bp_resume_busy: got %b, required 1", fetch_busy); end
        repeat (3) tick();
        checks++; if (rom_addr !== 32'hB) begin errors++; $display("FAIL bp_byte3_addr: got %h, required b", rom_addr); end
        tick();
        checks++; if (fetch_busy !== 1'b0 || rom_addr !== 32'hC) begin errors++; $display("FAIL bp_refull: got busy=%b addr=%h, required busy=0 addr=c", fetch_busy, rom_addr); end
        instr_ready = 1'b1;
        tick();
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid: got %b, required 0", instr_valid); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", sb_q.size()); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_partial();
        logic exp_v;
        apply_reset();
        instr_ready = 1'b1;
        push_exp(32'h0, exp_word(32'h0));
        repeat (7) tick();
        checks++; if (rom_addr !== 32'h7) begin errors++; $display("FAIL rp_pre_addr: got %h, required 7", rom_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        push_exp(32'h100, exp_word(32'h100));
        checks++; if (rom_addr !== 32'h100) begin errors++; $display("FAIL rp_target_addr: got %h, required 100", rom_addr); end
        for (int c = 8; c <= 12; c++) begin
            exp_v = (c == 12);
            checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL rp_valid c%0d: got %b, required %b", c, instr_valid, exp_v); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rp_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_redirect_full();
        logic exp_v;
        apply_reset();
        instr_ready = 1'b0;
        repeat (9) tick();
        checks++; if (instr_valid !== 1'b1 || fetch_busy !== 1'b0) begin errors++; $display("FAIL rf_full: got valid=%b busy=%b, required valid=1 busy=0", instr_valid, fetch_busy); end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_flush_valid: got %b, required 0", instr_valid); end
        checks++; if (rom_addr !== 32'h200 || fetch_busy !== 1'b1) begin errors++; $display("FAIL rf_restart: got addr=%h busy=%b, required addr=200 busy=1", rom_addr, fetch_busy); end
        push_exp(32'h200, exp_word(32'h200));
        for (int c = 10; c <= 14; c++) begin
            exp_v = (c == 14);
            checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL rf_valid c%0d: got %b, required %b", c, instr_valid, exp_v); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rf_drain: got %0d pending, required 0", sb_q.size()); end
        // Two redirects back to back: only the second target is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0041;
        tick();
        redirect_pc    = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        checks++; if (rom_addr !== 32'h80) begin errors++; $display("FAIL rf_last_wins_addr: got %h, required 80", rom_addr); end
        push_exp(32'h80, exp_word(32'h80));
        for (int c = 17; c <= 21; c++) begin
            exp_v = (c == 21);
            checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL rf_last_wins_valid c%0d: got %b, required %b", c, instr_valid, exp_v); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rf_last_wins_drain: got %0d pending, required 0", sb_q.size()); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            exp_addr = 32'hFFFF_FFFC + 32'(c);
            checks++; if (rom_addr_w !== exp_addr) begin errors++; $display("FAIL wrap_rom_addr c%0d: got %h, required %h", c, rom_addr_w, exp_addr); end
            if (c == 4) begin
                checks++; if (instr_valid_w !== 1'b1 || instr_pc_w !== 32'hFFFF_FFFC || instr_w !== exp_word(32'hFFFF_FFFC)) begin
                    errors++; $display("FAIL wrap_top_word: got v=%b pc=%h instr=%h, required v=1 pc=fffffffc instr=%h", instr_valid_w, instr_pc_w, instr_w, exp_word(32'hFFFF_FFFC));
                end
            end
            if (c == 8) begin
                checks++; if (instr_valid_w !== 1'b1 || instr_pc_w !== 32'h0 || instr_w !== exp_word(32'h0)) begin
                    errors++; $display("FAIL wrap_zero_word: got v=%b pc=%h instr=%h, required v=1 pc=0 instr=%h", instr_valid_w, instr_pc_w, instr_w, exp_word(32'h0));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        apply_reset();
        instr_ready = 1'b1;
        push_exp(32'h0, exp_word(32'h0));
        repeat (6) tick();
        checks++; if (rom_addr !== 32'h6) begin errors++; $display("FAIL rm_pre_addr: got %h, required 6", rom_addr); end
        rst = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b, required 0", instr_valid); end
        checks++; if (rom_addr !== 32'h0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL rm_restart: got addr=%h busy=%b, required addr=0 busy=1", rom_addr, fetch_busy); end
        rst = 1'b0;
        push_exp(32'h0, exp_word(32'h0));
        for (int c = 0; c <= 4; c++) begin
            exp_v = (c == 4);
            checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL rm_valid c%0d: got %b, required %b", c, instr_valid, exp_v); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rm_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_partial();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-time bound: the sequence above needs about 150 cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: got no completion after 100000 time units, required completion");
        $fatal(1);
    end

endmodule : tb_instr_fetch_seq

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Sequences instruction fetch from the byte-wide instruction ROM: drives one byte address per cycle and assembles four little-endian bytes into a 32-bit instruction.
- Owns the program counter and holds fetched words in a 2-entry prefetch buffer.
- Presents words to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump) that flush all in-flight and buffered work.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and ROM byte address.
- DATA_WIDTH, 32, instruction width; fixed at 4 bytes.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDRESS_WIDTH  byte address to ROM.
- rom_data  in  8  byte returned combinationally for rom_addr in the same cycle.
- instr  out  DATA_WIDTH  buffer head instruction.
- instr_pc  out  ADDRESS_WIDTH  PC of buffer head.
- instr_valid  out  1  buffer non-empty.
- instr_ready  in  1  consumer accepts head when instr_valid && instr_ready.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  ADDRESS_WIDTH  redirect target; bits [1:0] forced to 0.
- fetch_busy  out  1  high in FETCH state.

Behaviour:
- Reset, synchronous and active-high:
  - state=FETCH, byte_idx=0, pc=RESET_PC, buffer empty.
  - instr_valid=0; instr=0 and instr_pc=0 (both outputs are driven 0 whenever the buffer is empty).
  - rom_addr=RESET_PC.
- States:
  - FETCH: rom_addr = pc + byte_idx. Capture rom_data into assembly bits [8*byte_idx+7 : 8*byte_idx]; byte_idx increments.
    - At byte_idx=3: write {pc, assembled word} to the buffer, pc <= pc+4 (modulo 2^ADDRESS_WIDTH), byte_idx <= 0.
    - Next state is HOLD if the buffer count after this write/pop is 2, else FETCH.
  - HOLD: rom_addr = pc; no capture. Go to FETCH the cycle after a pop.
- Start rule: a word fetch begins only when buffer count ≤1. The count cannot rise during a fetch except by that fetch's own write, so a write never targets a full buffer.
- Latency and throughput:
  - First instruction valid 4 cycles after reset deasserts (cycle 4 if cycle 0 is the first non-reset cycle).
  - Steady state: one word per 4 cycles.
  - A word written at the end of cycle N is visible in cycle N+1.
- Handshake:
  - A pop occurs when instr_valid && instr_ready. Head advances next cycle.
  - instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - Pop and write in the same cycle are allowed. The count is unchanged and ordering is preserved.
- Redirect, sampled at a clock edge:
  - Buffer flushed; any partially assembled word discarded, including a byte_idx=3 cycle whose write is suppressed.
  - A pop in the same cycle is ignored.
  - Next cycle: state=FETCH, byte_idx=0, pc = redirect_pc & ~3.
  - Redirect in cycle N gives target instruction valid in cycle N+5.
  - Redirect in consecutive cycles: the last one wins.
- Priority: rst > redirect_valid > pop/write.
- Reset mid-fetch: all progress discarded; restart at RESET_PC.
- PC wrap: PC 0xFFFF_FFFC fetches bytes FC..FF, then pc wraps to 0. Byte addresses never cross a word boundary.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, HOLD}.
  - BYTES_PER_WORD=4.
  - fetch_entry_t struct {pc, instr}.
  - BUF_DEPTH=2.
- Sub-module fetch_buf: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head outputs. Flush has priority over push.

Test Plan:
- ROM bytes 0..7 = 13 05 A0 00 93 05 10 00, instr_ready=1, release reset → cycle 4: instr=0x00A00513, pc=0. Cycle 8: instr=0x00100593, pc=4. rom_addr sequence 0,1,2,3,4,...
- instr_ready=0 from reset → buffer fills with pcs 0 and 4; state HOLD with rom_addr=8 steady. Pulse ready once → pc 4 becomes head; fetch of pc 8 completes 4 cycles after FETCH resumes.
- Redirect to 0x0000_0103 in the byte_idx=3 cycle of pc 4 → pc 4 word never appears. Next rom_addr is 0x100, and pc 0x100 is valid 5 cycles after the redirect.
- Redirect asserted while buffer full and instr_ready=1 → no pop is observed, instr_valid=0 the next cycle, and fetch restarts at the target.
- RESET_PC=0xFFFF_FFFC → first word pc 0xFFFF_FFFC from bytes FC..FF, next pc=0.
- Assert rst at byte_idx=2 → next cycle instr_valid=0 and rom_addr=RESET_PC; resumes normally after rst deasserts.
